sign_rate_accumulator: RTL and testbench
========================================

// Module: sign_rate_accumulator
// PURPOSE
// - Initiator side of the sign-bit-cost start/done handshake in the CABAC bit-rate estimator.
// - Takes one 4x4 coefficient group's significance mask and requests one sign-bit cost per coded sign.
// - Applies sign data hiding (SDH) and accumulates the returned costs into a Q15 group sign rate.
// - Hands the rate to the RDOQ cost combiner over a valid/ready output.
// PARAMETERS
// - CG_SIZE        16      coefficients per group, mask width
// - ACC_W          32      accumulator/output rate width (Q15 fixed point)
// - SDH_THRESHOLD  4       minimum (last_pos - first_pos) that hides one sign
// - TIMEOUT_CYC    8       max cycles in WAIT before abort with err
// PORTS
// - clk            in   1       clock
// - rst            in   1       synchronous, active-high reset
// - in_valid       in   1       group request valid
// - in_ready       out  1       accepts a request; high only in IDLE
// - in_sig_mask    in   16      bit i = coefficient at scan pos i is nonzero
// - in_sdh_en      in   1       sign data hiding enabled for this group
// - cost_start     out  1       one-cycle request pulse to the sign cost unit
// - cost_done      in   1       cost unit response strobe
// - cost_in        in   32      cost unit result (Q15, 32768 = 1 bit)
// - out_valid      out  1       result valid; held until out_ready
// - out_ready      in   1       downstream accepts result
// - out_rate       out  ACC_W   summed sign cost, saturating
// - out_num_signs  out  5       number of signs actually coded (0..16)
// - out_err        out  1       request timed out; rate is partial
// BEHAVIOUR
// - Interface: one clock; reset is synchronous and active-high.
// - Reset: FSM=IDLE; in_ready=1, cost_start=0, out_valid=0, out_rate=0, out_num_signs=0, out_err=0.
// - IDLE: on in_valid&&in_ready, latch mask and sdh_en, clear acc/count/err; go to SCAN.
// - SCAN (1 cycle): compute first_pos (lowest set bit), last_pos (highest set bit).
//   Hide = sdh_en && mask!=0 && (last_pos-first_pos) >= SDH_THRESHOLD; if hide, clear mask bit first_pos.
//   Remaining mask==0 -> DONE, else -> REQ.
// - REQ: assert cost_start for exactly one cycle; -> WAIT, zero the timeout counter.
// - WAIT: on cost_done, acc = sat(acc + cost_in), count++, clear lowest set mask bit;
//   mask now 0 -> DONE, else -> REQ. cost_done outside WAIT is ignored.
//   If TIMEOUT_CYC cycles elapse without cost_done: set out_err, -> DONE with partial acc.
// - DONE: out_valid=1 with out_rate/out_num_signs/out_err stable; on out_ready -> IDLE.
// - Back-to-back: min per sign 2 cycles (REQ + WAIT with done next cycle); group latency = 2+2N+1 cycles.
// - Saturation: acc + cost_in computed at ACC_W+1 bits; overflow clamps to all-ones, never wraps.
// - Outputs hold last result after handshake until the next group enters DONE.
// - Reset mid-operation: returns to IDLE next edge; any later cost_done is ignored.
// - in_ready is 0 in all non-IDLE states; requests are never queued.
// STRUCTURE
// - Package rdoq_cabac_pkg: IEP_RATE=32768, sign_acc_state_e {IDLE,SCAN,REQ,WAIT,DONE}, Q15 width constants.
// - Sub-module cg_sig_priority: combinational 16-bit lowest/highest set-bit finder (first_pos, last_pos, any).
// - FSM, accumulator, counter and timeout counter live in this module.
// TESTING
// - mask=0x0000, sdh=0 -> no cost_start, out_rate=0, out_num_signs=0, out_valid 3 cycles after accept.
// - mask=0xFFFF, sdh=0, stub returns 32768 one cycle after start -> 16 starts, out_rate=524288, num=16.
// - mask=0x8001, sdh=1 (distance 15) -> 1 start, out_rate=32768, num=1.
// - mask=0x0005, sdh=1 (distance 2) -> 2 starts, out_rate=65536; same mask with 0x0011 -> 1 start, 32768.
// - Stub returns 0xF0000000 on mask=0x0003 -> out_rate=0xFFFFFFFF (saturated), num=2.
// - Stub never answers -> out_err=1 after TIMEOUT_CYC cycles, num=0; out_ready low 5 cycles keeps outputs stable;
//   rst asserted in WAIT -> IDLE, in_ready=1, late cost_done ignored.

Source files
------------

// File: rtl/sign_rate_accumulator_pkg.sv
// Shared constants and FSM state type for the CABAC sign-rate path.
package rdoq_cabac_pkg;
    localparam int CG_SIZE           = 16;
    localparam int ACC_W             = 32;
    localparam int Q15_FRAC_W        = 15;
    localparam int POS_W             = 4;
    localparam int CNT_W             = 5;
    localparam int TMO_W             = 8;
    localparam int SDH_THRESHOLD_DEF = 4;
    localparam int TIMEOUT_CYC_DEF   = 8;

    localparam logic [ACC_W-1:0] IEP_RATE = ACC_W'(32768);

    typedef enum logic [2:0] {
        IDLE,
        SCAN,
        REQ,
        WAIT,
        DONE
    } sign_acc_state_e;
endpackage

// File: rtl/sign_rate_accumulator_if.sv
// Request, cost-unit and result handshakes of the sign-rate accumulator.
interface sign_rate_accumulator_if;
    import rdoq_cabac_pkg::*;

    logic               in_valid;
    logic               in_ready;
    logic [CG_SIZE-1:0] in_sig_mask;
    logic               in_sdh_en;
    logic               cost_start;
    logic               cost_done;
    logic [ACC_W-1:0]   cost_in;
    logic               out_valid;
    logic               out_ready;
    logic [ACC_W-1:0]   out_rate;
    logic [CNT_W-1:0]   out_num_signs;
    logic               out_err;

    modport master (
        output in_valid, in_sig_mask, in_sdh_en,
        output cost_done, cost_in, out_ready,
        input  in_ready, cost_start,
        input  out_valid, out_rate, out_num_signs, out_err
    );

    modport slave (
        input  in_valid, in_sig_mask, in_sdh_en,
        input  cost_done, cost_in, out_ready,
        output in_ready, cost_start,
        output out_valid, out_rate, out_num_signs, out_err
    );
endinterface

// File: rtl/sign_rate_accumulator_cg_sig_priority.sv
// Lowest/highest set-bit finder over a coefficient-group significance mask.
module cg_sig_priority
    import rdoq_cabac_pkg::*;
(
    input  logic [CG_SIZE-1:0] i_mask,
    output logic [POS_W-1:0]   o_first_pos,
    output logic [POS_W-1:0]   o_last_pos,
    output logic               o_any
);
    always_comb begin
        o_first_pos = '0;
        o_last_pos  = '0;
        for (int i = CG_SIZE - 1; i >= 0; i--) begin
            if (i_mask[i]) o_first_pos = POS_W'(i);
        end
        for (int i = 0; i < CG_SIZE; i++) begin
            if (i_mask[i]) o_last_pos = POS_W'(i);
        end
        o_any = |i_mask;
    end
endmodule

// File: rtl/sign_rate_accumulator.sv
// Requests one sign cost per coded sign of a 4x4 group (with SDH) and
// accumulates the Q15 costs into a saturating group sign rate.
module sign_rate_accumulator
    import rdoq_cabac_pkg::*;
#(
    parameter int SDH_THRESHOLD = SDH_THRESHOLD_DEF,
    parameter int TIMEOUT_CYC   = TIMEOUT_CYC_DEF
) (
    input  logic                    clk,
    input  logic                    rst,
    sign_rate_accumulator_if.slave  bus
);
    sign_acc_state_e    r_state;
    sign_acc_state_e    w_state_nxt;
    logic [CG_SIZE-1:0] r_mask;
    logic [CG_SIZE-1:0] w_mask_nxt;
    logic               r_sdh;
    logic [ACC_W-1:0]   r_acc;
    logic [ACC_W-1:0]   w_acc_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic               r_err;
    logic               w_err_nxt;
    logic [TMO_W-1:0]   r_tmo;
    logic [ACC_W-1:0]   r_out_rate;
    logic [CNT_W-1:0]   r_out_num;
    logic               r_out_err;

    logic [POS_W-1:0]   w_first;
    logic [POS_W-1:0]   w_last;
    logic               w_any;
    logic [POS_W-1:0]   w_dist;
    logic               w_hide;
    logic [CG_SIZE-1:0] w_scan_mask;
    logic [CG_SIZE-1:0] w_mask_clr;
    logic [ACC_W:0]     w_sum;
    logic [ACC_W-1:0]   w_sat;
    logic               w_timeout;
    logic               w_start;
    logic               w_in_ready;

    cg_sig_priority u_prio (
        .i_mask      (r_mask),
        .o_first_pos (w_first),
        .o_last_pos  (w_last),
        .o_any       (w_any)
    );

    // SDH drops the sign of the first coefficient when the span is wide enough.
    assign w_dist      = w_last - w_first;
    assign w_hide      = r_sdh && w_any && (int'(w_dist) >= SDH_THRESHOLD);
    assign w_scan_mask = w_hide ? (r_mask & ~(CG_SIZE'(1) << w_first))
                                : r_mask;
    assign w_mask_clr  = r_mask & (r_mask - CG_SIZE'(1));
    assign w_sum       = {1'b0, r_acc} + {1'b0, bus.cost_in};
    assign w_sat       = w_sum[ACC_W] ? '1 : w_sum[ACC_W-1:0];
    assign w_timeout   = (int'(r_tmo) >= TIMEOUT_CYC - 1);

    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        w_mask_nxt  = r_mask;
        w_acc_nxt   = r_acc;
        w_cnt_nxt   = r_cnt;
        w_err_nxt   = r_err;
        w_start     = 1'b0;
        w_in_ready  = 1'b0;
        unique case (r_state)
            IDLE: begin
                w_in_ready = 1'b1;
                if (bus.in_valid) begin
                    w_state_nxt = SCAN;
                    w_mask_nxt  = bus.in_sig_mask;
                    w_acc_nxt   = '0;
                    w_cnt_nxt   = '0;
                    w_err_nxt   = 1'b0;
                end
            end
            SCAN: begin
                w_mask_nxt  = w_scan_mask;
                w_state_nxt = (w_scan_mask == '0) ? DONE : REQ;
            end
            REQ: begin
                w_start     = 1'b1;
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (bus.cost_done) begin
                    w_acc_nxt   = w_sat;
                    w_cnt_nxt   = r_cnt + CNT_W'(1);
                    w_mask_nxt  = w_mask_clr;
                    w_state_nxt = (w_mask_clr == '0) ? DONE : REQ;
                end else if (w_timeout) begin
                    w_err_nxt   = 1'b1;
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                if (bus.out_ready) w_state_nxt = IDLE;
            end
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mask     <= '0;
            r_sdh      <= 1'b0;
            r_acc      <= '0;
            r_cnt      <= '0;
            r_err      <= 1'b0;
            r_tmo      <= '0;
            r_out_rate <= '0;
            r_out_num  <= '0;
            r_out_err  <= 1'b0;
        end else begin
            r_mask <= w_mask_nxt;
            r_acc  <= w_acc_nxt;
            r_cnt  <= w_cnt_nxt;
            r_err  <= w_err_nxt;
            if (r_state == IDLE && bus.in_valid) r_sdh <= bus.in_sdh_en;
            if (r_state == REQ)       r_tmo <= '0;
            else if (r_state == WAIT) r_tmo <= r_tmo + TMO_W'(1);
            // Result registers change only on DONE entry so they hold across groups.
            if (w_state_nxt == DONE && r_state != DONE) begin
                r_out_rate <= w_acc_nxt;
                r_out_num  <= w_cnt_nxt;
                r_out_err  <= w_err_nxt;
            end
        end
    end

    assign bus.in_ready      = w_in_ready;
    assign bus.cost_start    = w_start;
    assign bus.out_valid     = (r_state == DONE);
    assign bus.out_rate      = r_out_rate;
    assign bus.out_num_signs = r_out_num;
    assign bus.out_err       = r_out_err;
endmodule

// File: tb/tb_sign_rate_accumulator.sv
// Directed bench for sign_rate_accumulator with a one-cycle cost-unit stub.
module tb_sign_rate_accumulator;
    logic clk = 1'b0;
    logic rst = 1'b1;

    sign_rate_accumulator_if bus ();

    logic        stub_en   = 1'b0;
    logic        stub_done = 1'b0;
    logic        tb_done   = 1'b0;
    logic [31:0] stub_cost = 32'd32768;
    int          n_starts  = 0;
    int          n_cmp     = 0;
    int          n_bad     = 0;
    int          base;
    int          lat;

    assign bus.cost_done = stub_done | tb_done;
    assign bus.cost_in   = stub_cost;

    sign_rate_accumulator dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Stub: a start seen in one cycle yields cost_done in the following cycle.
    always @(posedge clk) begin
        logic saw;
        saw = bus.cost_start;
        #1;
        if (saw) n_starts++;
        stub_done = stub_en && saw;
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    task automatic start_group(input logic [15:0] mask, input logic sdh);
        base = n_starts;
        @(posedge clk);
        #2;
        bus.in_valid    = 1'b1;
        bus.in_sig_mask = mask;
        bus.in_sdh_en   = sdh;
        @(posedge clk);
        #2;
        bus.in_valid = 1'b0;
        lat = 2;
    endtask

    task automatic wait_done();
        while (!bus.out_valid && lat < 200) begin
            @(posedge clk);
            #2;
            lat++;
        end
        chk("done_bound", 32'(bus.out_valid), 32'd1);
    endtask

    task automatic finish_group();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #2;
        bus.out_ready = 1'b0;
    endtask

    task automatic run(input string tag, input logic [15:0] mask,
                       input logic sdh, input int exp_starts,
                       input logic [31:0] exp_rate, input int exp_num,
                       input int exp_lat);
        start_group(mask, sdh);
        wait_done();
        chk({tag, "_lat"},    32'(lat), 32'(exp_lat));
        chk({tag, "_starts"}, 32'(n_starts - base), 32'(exp_starts));
        chk({tag, "_rate"},   bus.out_rate, exp_rate);
        chk({tag, "_num"},    32'(bus.out_num_signs), 32'(exp_num));
        chk({tag, "_err"},    32'(bus.out_err), 32'd0);
        finish_group();
    endtask

    initial begin
        bus.in_valid    = 1'b0;
        bus.in_sig_mask = '0;
        bus.in_sdh_en   = 1'b0;
        bus.out_ready   = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        rst = 1'b0;
        chk("rst_in_ready",   32'(bus.in_ready), 32'd1);
        chk("rst_cost_start", 32'(bus.cost_start), 32'd0);
        chk("rst_out_valid",  32'(bus.out_valid), 32'd0);
        chk("rst_out_rate",   bus.out_rate, 32'd0);
        chk("rst_out_num",    32'(bus.out_num_signs), 32'd0);
        chk("rst_out_err",    32'(bus.out_err), 32'd0);

        stub_en   = 1'b1;
        stub_cost = 32'd32768;
        run("empty",   16'h0000, 1'b0, 0,  32'd0,      0,  3);
        run("full",    16'hFFFF, 1'b0, 16, 32'd524288, 16, 35);
        run("sdh_far", 16'h8001, 1'b1, 1,  32'd32768,  1,  5);
        run("sdh_d2",  16'h0005, 1'b1, 2,  32'd65536,  2,  7);
        run("sdh_d4",  16'h0011, 1'b1, 1,  32'd32768,  1,  5);

        stub_cost = 32'hF000_0000;
        run("sat",     16'h0003, 1'b0, 2,  32'hFFFF_FFFF, 2, 7);
        chk("hold_valid", 32'(bus.out_valid), 32'd0);
        chk("hold_rate",  bus.out_rate, 32'hFFFF_FFFF);

        // No answer from the cost unit: 8 WAIT cycles then DONE with err.
        stub_en   = 1'b0;
        stub_cost = 32'd32768;
        start_group(16'h0001, 1'b0);
        chk("tmo_busy_ready", 32'(bus.in_ready), 32'd0);
        chk("tmo_hold_rate",  bus.out_rate, 32'hFFFF_FFFF);
        wait_done();
        chk("tmo_lat",  32'(lat), 32'd12);
        chk("tmo_err",  32'(bus.out_err), 32'd1);
        chk("tmo_num",  32'(bus.out_num_signs), 32'd0);
        chk("tmo_rate", bus.out_rate, 32'd0);
        chk("tmo_starts", 32'(n_starts - base), 32'd1);
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #2;
            chk("stall_valid", 32'(bus.out_valid), 32'd1);
            chk("stall_err",   32'(bus.out_err), 32'd1);
            chk("stall_num",   32'(bus.out_num_signs), 32'd0);
        end
        finish_group();
        chk("tmo_post_ready", 32'(bus.in_ready), 32'd1);
        chk("tmo_post_err",   32'(bus.out_err), 32'd1);

        // Reset while waiting on the cost unit; a late done must be ignored.
        start_group(16'h0003, 1'b0);
        repeat (3) @(posedge clk);
        #2;
        chk("mid_busy", 32'(bus.in_ready), 32'd0);
        rst = 1'b1;
        @(posedge clk);
        #2;
        rst = 1'b0;
        chk("mid_rst_ready", 32'(bus.in_ready), 32'd1);
        chk("mid_rst_valid", 32'(bus.out_valid), 32'd0);
        chk("mid_rst_err",   32'(bus.out_err), 32'd0);
        tb_done = 1'b1;
        @(posedge clk);
        #2;
        tb_done = 1'b0;
        @(posedge clk);
        #2;
        chk("late_ready", 32'(bus.in_ready), 32'd1);
        chk("late_valid", 32'(bus.out_valid), 32'd0);
        chk("late_rate",  bus.out_rate, 32'd0);
        chk("late_num",   32'(bus.out_num_signs), 32'd0);

        stub_en = 1'b1;
        run("after_rst", 16'h0100, 1'b0, 1, 32'd32768, 1, 5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
